// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register/word types and the
// byte-lane merge used by both the register file and the operand bypass.
package cpu_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREG  = 32;
    localparam int NBYTE = 4;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [DW-1:0]    word_t;
    typedef logic [NBYTE-1:0] byte_en_t;

    typedef enum logic [0:0] {
        OF_EMPTY = 1'b0,
        OF_FULL  = 1'b1
    } of_state_t;

    // Replace each byte lane of old_w whose enable is set with the lane from new_w.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w, input byte_en_t we);
        word_t merged;
        merged = old_w;
        for (int i = 0; i < NBYTE; i++) begin
            if (we[i]) begin
                merged[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction with a destination is issued and cleared by its write-back.
// Lookups see the same-cycle write-back as already retired (pend_eff).
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] rd_addr,
    output logic          rs1_pend,
    output logic          rs2_pend,
    output logic          rd_pend
);

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pend_eff_s;
    logic [NREG-1:0] pending_next_s;

    // Effective pending view: a write-back landing this cycle releases its register.
    always_comb begin
        pend_eff_s = pending_r;
        if (clr_en) begin
            pend_eff_s[clr_addr] = 1'b0;
        end else begin
            pend_eff_s = pending_r;
        end
        pend_eff_s[0] = 1'b0;
    end

    assign rs1_pend = pend_eff_s[rs1_addr];
    assign rs2_pend = pend_eff_s[rs2_addr];
    assign rd_pend  = pend_eff_s[rd_addr];

    // Next pending vector: clear first, then set, so a same-cycle set wins.
    always_comb begin
        pending_next_s = pend_eff_s;
        if (set_en) begin
            pending_next_s[set_addr] = 1'b1;
        end else begin
            pending_next_s = pend_eff_s;
        end
        pending_next_s[0] = 1'b0;
    end

    // Pending register state; register 0 never becomes pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {NREG{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand fetch: reads two sources from the register file,
// merges a same-cycle write-back into them, blocks on in-flight producers and
// hands a registered operand bundle to execute over valid/ready.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [AW-1:0] in_rd,
    input  logic [3:0]    in_rd_we,
    output logic [AW-1:0] RR1,
    output logic [AW-1:0] RR2,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [3:0]    wb_we,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [AW-1:0] out_rd,
    output logic [3:0]    out_rd_we
);

    of_state_t     state_r;
    logic          out_valid_r;
    logic [DW-1:0] out_op1_r;
    logic [DW-1:0] out_op2_r;
    logic [AW-1:0] out_rd_r;
    logic [3:0]    out_rd_we_r;

    logic          rs1_pend_s;
    logic          rs2_pend_s;
    logic          rd_pend_s;
    logic          rd_writes_s;
    logic          hazard_s;
    logic          accept_s;
    logic          set_en_s;
    logic          clr_en_s;
    logic [DW-1:0] op1_s;
    logic [DW-1:0] op2_s;

    assign RR1 = in_rs1;
    assign RR2 = in_rs2;

    assign rd_writes_s = (in_rd_we != 4'd0) && (in_rd != {AW{1'b0}});
    assign clr_en_s    = wb_valid && (wb_we != 4'd0);
    assign set_en_s    = accept_s && rd_writes_s;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en_s),
        .set_addr (in_rd),
        .clr_en   (clr_en_s),
        .clr_addr (wb_addr),
        .rs1_addr (in_rs1),
        .rs2_addr (in_rs2),
        .rd_addr  (in_rd),
        .rs1_pend (rs1_pend_s),
        .rs2_pend (rs2_pend_s),
        .rd_pend  (rd_pend_s)
    );

    // Issue gating: stall on a pending source or a pending destination (WAW).
    always_comb begin
        hazard_s = 1'b0;
        if (in_rs1 != {AW{1'b0}} && rs1_pend_s) begin
            hazard_s = 1'b1;
        end else if (in_rs2 != {AW{1'b0}} && rs2_pend_s) begin
            hazard_s = 1'b1;
        end else if (rd_writes_s && rd_pend_s) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = ~hazard_s & (~out_valid_r | out_ready);
    assign accept_s = in_valid & in_ready;

    // Source 1 resolution: r0 is zero, otherwise merge any same-cycle write-back lanes.
    always_comb begin
        op1_s = RD1;
        if (in_rs1 == {AW{1'b0}}) begin
            op1_s = {DW{1'b0}};
        end else if (wb_valid && (wb_addr == in_rs1)) begin
            op1_s = byte_merge(RD1, wb_data, wb_we);
        end else begin
            op1_s = RD1;
        end
    end

    // Source 2 resolution: same rules as source 1.
    always_comb begin
        op2_s = RD2;
        if (in_rs2 == {AW{1'b0}}) begin
            op2_s = {DW{1'b0}};
        end else if (wb_valid && (wb_addr == in_rs2)) begin
            op2_s = byte_merge(RD2, wb_data, wb_we);
        end else begin
            op2_s = RD2;
        end
    end

    // Output stage FSM: load a bundle on accept, drain on out_ready, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= OF_EMPTY;
            out_valid_r <= 1'b0;
            out_op1_r   <= {DW{1'b0}};
            out_op2_r   <= {DW{1'b0}};
            out_rd_r    <= {AW{1'b0}};
            out_rd_we_r <= 4'd0;
        end else begin
            case (state_r)
                OF_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= OF_FULL;
                        out_valid_r <= 1'b1;
                        out_op1_r   <= op1_s;
                        out_op2_r   <= op2_s;
                        out_rd_r    <= in_rd;
                        out_rd_we_r <= in_rd_we;
                    end else begin
                        state_r     <= OF_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                OF_FULL: begin
                    if (accept_s) begin
                        state_r     <= OF_FULL;
                        out_valid_r <= 1'b1;
                        out_op1_r   <= op1_s;
                        out_op2_r   <= op2_s;
                        out_rd_r    <= in_rd;
                        out_rd_we_r <= in_rd_we;
                    end else if (out_ready) begin
                        state_r     <= OF_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= OF_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= OF_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_op1   = out_op1_r;
    assign out_op2   = out_op2_r;
    assign out_rd    = out_rd_r;
    assign out_rd_we = out_rd_we_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed issues push hand-computed
// bundles into a queue, a negedge monitor pops and compares on each transfer
// and also checks that a stalled bundle stays stable.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_rd_we;
    logic [4:0]  RR1, RR2;
    logic [31:0] RD1, RD2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [3:0]  wb_we;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic [3:0]  out_rd_we;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic [3:0]  we;
    } bundle_t;

    bundle_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] regs [32];
    bit          load_regs = 1'b1;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .RR1       (RR1),
        .RR2       (RR2),
        .RD1       (RD1),
        .RD2       (RD2),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_we     (wb_we),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we)
    );

    function automatic logic [31:0] tb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] we);
        logic [31:0] mask;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Register file model: combinational read of the pre-write value, write on the edge.
    assign RD1 = regs[RR1];
    assign RD2 = regs[RR2];
    always @(posedge clk) begin
        if (load_regs) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            regs[0] <= 32'hDEADBEEF;
            regs[1] <= 32'h11111111;
            regs[3] <= 32'h33333333;
            regs[4] <= 32'h44444444;
            regs[9] <= 32'h99999999;
        end else if (wb_valid && wb_addr != 5'd0) begin
            regs[wb_addr] <= tb_merge(regs[wb_addr], wb_data, wb_we);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual op1=%h op2=%h rd=%0d we=%b expected op1=%h op2=%h rd=%0d we=%b",
                     name, act.op1, act.op2, act.rd, act.we, exp.op1, exp.op2, exp.rd, exp.we);
        end
    endtask

    // Monitor: compare every transferred bundle and the stability of a held one.
    bundle_t held_b;
    bit      held = 1'b0;
    always @(negedge clk) begin
        bundle_t cur;
        bundle_t exp;
        cur = '{op1: out_op1, op2: out_op2, rd: out_rd, we: out_rd_we};
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && out_valid) check_bundle("hold_stable", cur, held_b);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bundle actual op1=%h op2=%h rd=%0d required none",
                             cur.op1, cur.op2, cur.rd);
                end else begin
                    exp = exp_q.pop_front();
                    check_bundle("bundle", cur, exp);
                end
            end
            held   = out_valid && !out_ready;
            held_b = cur;
        end
    end

    // Present one instruction, wait (bounded) for acceptance, push its expected bundle.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] we, input logic [31:0] e1, input logic [31:0] e2,
                         input bit immediate, input string name);
        int waited;
        bit ok;
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back('{op1: e1, op2: e2, rd: rd, we: we});
            end else begin
                waited++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_accept required=accept", name);
        end
        if (immediate) check({name, "_ready"}, waited, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Hold the presented instruction for n cycles, expecting in_ready low each cycle.
    task automatic stall_check(input int n, input string name);
        repeat (n) begin
            @(negedge clk);
            check(name, {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a, input logic [3:0] we, input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_we    = we;
        wb_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 4'd0;
        out_ready = 1'b1;
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_regs = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_op1", out_op1, 32'd0);
        check("rst_out_op2", out_op2, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_rd_we", {28'd0, out_rd_we}, 32'd0);
        @(posedge clk);
        #1;
        issue(5'd1, 5'd1, 5'd2, 4'b0000, 32'h11111111, 32'h11111111, 1'b1, "first_after_reset");

        // Plain read; r0 reads zero although the file returns DEADBEEF
        issue(5'd1, 5'd0, 5'd5, 4'b0000, 32'h11111111, 32'h00000000, 1'b1, "plain_read");

        // Byte bypass on both sources
        set_wb(1'b1, 5'd1, 4'b0011, 32'h22222222);
        issue(5'd1, 5'd1, 5'd10, 4'b0000, 32'h11112222, 32'h11112222, 1'b1, "byte_bypass");
        // Write-back to r0 must not bypass
        set_wb(1'b1, 5'd0, 4'b1111, 32'hFFFFFFFF);
        issue(5'd0, 5'd1, 5'd11, 4'b0000, 32'h00000000, 32'h11112222, 1'b1, "r0_no_bypass");
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);

        // RAW stall released by same-cycle write-back
        issue(5'd0, 5'd0, 5'd3, 4'b1111, 32'h0, 32'h0, 1'b1, "producer_r3");
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd6; in_rd_we = 4'b0000;
        stall_check(3, "raw_stall");
        set_wb(1'b1, 5'd3, 4'b1111, 32'hAAAA5555);
        issue(5'd3, 5'd0, 5'd6, 4'b0000, 32'hAAAA5555, 32'h0, 1'b1, "raw_release");
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);

        // Execute backpressure
        issue(5'd1, 5'd3, 5'd7, 4'b0000, 32'h11112222, 32'hAAAA5555, 1'b1, "bp_first");
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd1; in_rd = 5'd8; in_rd_we = 4'b0000;
        stall_check(3, "bp_stall");
        out_ready = 1'b1;
        issue(5'd4, 5'd1, 5'd8, 4'b0000, 32'h44444444, 32'h11112222, 1'b1, "bp_release");
        @(negedge clk);
        check("bp_no_bubble", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Set/clear collision on r4: set wins
        issue(5'd0, 5'd0, 5'd4, 4'b1111, 32'h0, 32'h0, 1'b1, "producer_r4");
        set_wb(1'b1, 5'd4, 4'b1111, 32'h55556666);
        issue(5'd0, 5'd0, 5'd4, 4'b0011, 32'h0, 32'h0, 1'b1, "collision_waw");
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);
        in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd0; in_rd = 5'd12; in_rd_we = 4'b0000;
        stall_check(3, "collision_stall");
        set_wb(1'b1, 5'd4, 4'b0011, 32'h77778888);
        issue(5'd4, 5'd0, 5'd12, 4'b0000, 32'h55558888, 32'h0, 1'b1, "collision_release");
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);

        // Reset mid-operation drops the held bundle and pending bits
        issue(5'd0, 5'd0, 5'd9, 4'b1111, 32'h0, 32'h0, 1'b1, "producer_r9");
        out_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_op1", out_op1, 32'd0);
        check("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        @(posedge clk);
        #1;
        issue(5'd9, 5'd0, 5'd0, 4'b1111, 32'h99999999, 32'h0, 1'b1, "after_rst_r9");
        set_wb(1'b1, 5'd9, 4'b1111, 32'h12345678);
        issue(5'd0, 5'd9, 5'd0, 4'b0000, 32'h0, 32'h12345678, 1'b1, "late_wb");
        set_wb(1'b0, 5'd0, 4'd0, 32'd0);
        issue(5'd9, 5'd1, 5'd13, 4'b0000, 32'h12345678, 32'h11112222, 1'b1, "final_read");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-side read master for the 2-read/1-write register file. Accepts one decoded instruction per cycle, drives the register file read addresses, merges same-cycle write-back bytes into the read data, and tracks in-flight destination registers in a scoreboard so that no operand is read before its producer has written back. It sits between decode and execute and presents a registered operand bundle to execute over a valid/ready handshake.

## Interface
- DW, 32, data width; must be 32, since the byte-enable width is fixed at 4
- AW, 5, register address width (32 registers)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid is also high
- in_rs1, in_rs2  in  AW  source register numbers
- in_rd  in  AW  destination register number
- in_rd_we  in  4  destination byte enables; 0 means no write
- RR1, RR2  out  AW  register file read addresses; combinational copies of in_rs1 and in_rs2
- RD1, RD2  in  DW  register file read data; combinational, returns the pre-write value
- wb_valid  in  1  write-back occurring this cycle (same signals that drive the register file write port)
- wb_addr  in  AW  write-back register
- wb_we  in  4  write-back byte enables
- wb_data  in  DW  write-back data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts the bundle
- out_op1, out_op2  out  DW  resolved operands
- out_rd  out  AW  destination register, passed through
- out_rd_we  out  4  destination byte enables, passed through

## Operation
**Write-back bypass**
- For each source operand: if wb_valid, wb_addr equals rs, and rs is not 0, then for each byte i where wb_we[i]=1, operand byte i comes from wb_data; otherwise it comes from RDx.
- Register 0 always reads as 0, whatever RDx returns.

**Scoreboard**
- The scoreboard holds one pending bit per register; bit 0 is hard-wired to 0.
- Effective pending for the current cycle: pend_eff[r] = pending[r] & ~(wb_valid & wb_addr==r & wb_we!=0).
- Hazard when any of the following is true:
  - pend_eff[in_rs1], for rs1 not 0;
  - pend_eff[in_rs2], for rs2 not 0;
  - pend_eff[in_rd], for in_rd_we not 0 and in_rd not 0 (write-after-write).
- in_ready = ~hazard & (~out_valid | out_ready).
- On accept with in_rd_we not 0 and in_rd not 0: set pending[in_rd].
- On write-back (wb_valid and wb_we not 0): clear pending[wb_addr].
- Set and clear of the same register in the same cycle: set wins, so the bit stays 1.
- A write-back to a register that is not pending is harmless; the bit stays 0.

**Output stage**
- Two-state FSM, EMPTY and FULL:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept while out_ready is high (new bundle loaded).
  - FULL → EMPTY when out_ready is high and there is no accept.
- out_valid = (state == FULL).
- The bundle is held stable while out_valid & ~out_ready.

## Timing
- Latency is 1 cycle: an instruction accepted in cycle N appears on the outputs in cycle N+1.
- Throughput is 1 per cycle when there is no hazard and execute is not stalled.
- The RR1/RR2 to RD1/RD2 path is combinational within the cycle.
- Bypass applies only to a write-back in the same cycle as the accept. Later write-backs do not update a bundle that is already held; the scoreboard guarantees none target it.
- Reset values:
  - state EMPTY, out_valid 0;
  - out_op1, out_op2 and out_rd are 0, out_rd_we is 0;
  - all pending bits are 0.
- in_ready is 1 in the first cycle after reset if in_valid is present and there is no hazard.
- Reset mid-operation drops the held bundle and all pending bits. Write-backs arriving after reset for pre-reset instructions are ignored by the scoreboard.

## Structure
- Shared package `cpu_pkg`:
  - DW and AW constants;
  - reg_addr_t and word_t typedefs;
  - byte_merge(old, new, we) function, also used by the register file.
- Sub-module `reg_scoreboard`:
  - holds the 32-bit pending vector and implements the set/clear rules;
  - exposes pend_eff lookups for three addresses (rs1, rs2, rd).

## Test plan
- **Reset:** hold rst for 2 cycles, then release → out_valid=0, all pending bits 0, in_ready=1 with in_valid=1, rs1=rs2=1, rd=2, in_rd_we=0.
- **Plain read:** register 1 holds 0x11111111; issue rs1=1, rs2=0 → next cycle out_op1=0x11111111, out_op2=0.
- **Byte bypass:** RD1=0x11111111 with wb_addr=1, wb_we=4'b0011, wb_data=0x22222222 in the same cycle → out_op1=0x11112222.
- **RAW stall:** issue rd=3, we=1111; next cycle issue rs1=3 → in_ready=0 until the cycle of a wb to register 3 with data 0xAAAA5555; accepted that cycle with out_op1=0xAAAA5555.
- **Execute backpressure:** out_ready=0 for 3 cycles → bundle held unchanged and in_ready=0. Raise out_ready → next bundle loads the following cycle with no bubble.
- **Set/clear collision:** register 4 is pending; the wb to register 4 and the accept of a new rd=4 occur in the same cycle → pending[4] stays 1, and a following rs1=4 stalls.
